cpu_exu_issue: RTL and testbench
================================

Name: cpu_exu_issue

Overview:
- Issue/writeback front end that drives the EXU's operand interface: alu_ctrl, in1, in2, wait_exe.
- Queues decoded ops in a small FIFO and reads the register file.
- Forwards the EXU's registered result to a dependent op issued on the next cycle.
- Tags each result with its destination so the result returns to the register file in the same cycle it appears on the EXU output.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_flag  in  1  pipeline flush; same signal as the EXU flush
stall_in  in  1  downstream hold; no issue while high
dec_valid  in  1  decoded op valid
dec_ready  out  1  FIFO can accept
dec_alu_ctrl  in  5  `ALU_* code from command.vh
dec_rs1  in  5  source 1 index
dec_rs2  in  5  source 2 index
dec_rd  in  5  destination index
dec_rd_we  in  1  op writes rd
dec_use_imm  in  1  in2 = immediate
dec_imm  in  32  immediate
rf_rs1_addr  out  5  RF read address 1
rf_rs1_data  in  32  RF read data 1 (combinational)
rf_rs2_addr  out  5  RF read address 2
rf_rs2_data  in  32  RF read data 2 (combinational)
exu_alu_ctrl  out  5  to EXU alu_ctrl
exu_in1  out  32  to EXU in1
exu_in2  out  32  to EXU in2
exu_wait  out  1  to EXU wait_exe
exu_out  in  32  EXU registered result
wb_en  out  1  RF write enable
wb_rd  out  5  RF write index
wb_data  out  32  RF write data

Behaviour:

Reset and registers:
- Reset is synchronous, active-low, on rst_n; clock is clk.
- Reset: FIFO empty, count=0, ex_valid=0, ex_rd=0, ex_we=0.
- While rst_n=0: dec_ready=0, exu_wait=1, wb_en=0.

FIFO:
- Registered storage with wrapping read/write pointers and a count 0..DEPTH.
- dec_ready = rst_n & ~flush_flag & (count!=DEPTH). Pop does not feed ready, so there is no push when full, even with a simultaneous pop.
- push = dec_valid & dec_ready.
- issue = ~empty & ~stall_in & ~flush_flag. issue pops the head.
- Push and pop in the same cycle: count unchanged.

Issue (combinational from the head entry):
- rf_rs1_addr/rf_rs2_addr = head rs1/rs2.
- exu_alu_ctrl = head ctrl.
- exu_wait = ~issue. The EXU then outputs 0 next cycle.
- With issue=0, exu_alu_ctrl/in1/in2 are don't-care.

Forwarding:
- fwd1 = ex_valid & ex_we & (ex_rd!=0) & (ex_rd==head rs1); fwd2 is the same test against head rs2.
- exu_in1 = fwd1 ? exu_out : rf_rs1_data.
- exu_in2 = use_imm ? imm : (fwd2 ? exu_out : rf_rs2_data).
- x0 is never forwarded.

EX tag stage (registered each clk):
- ex_valid <= issue.
- ex_rd <= head rd; ex_we <= head rd_we.
- Latency: op issued in cycle N; its result is on exu_out and the wb_* outputs in cycle N+1.
- The RF write lands at the end of N+1; an op issued in N+2 reads the RF value directly.

Writeback:
- wb_en = ex_valid & ex_we & (ex_rd!=0) & ~flush_flag.
- wb_rd = ex_rd; wb_data = exu_out.

Flush:
- In the flush cycle: no push, no issue, wb_en=0.
- Next edge: FIFO empty, ex_valid=0.
- The cycle after flush: dec_ready=1, wb_en=0.

stall_in:
- Holds the head entry. ex_valid goes 0, so no writeback; the in-flight result of the previous op still writes back normally.
- An op held by stall_in is re-forwarded correctly, because its sources are re-read each cycle.

Optional Feature:
ISSUE_BYPASS_EN
- Defined: when the FIFO is empty and dec_valid & dec_ready & ~stall_in, the decode op issues in the same cycle.
  - Source is the dec_* ports, with the same forwarding rules.
  - The op is not written to the FIFO.
  - Zero added latency.
- Undefined: every op passes through the FIFO; minimum one cycle from push to issue.

Test Plan:
1. rst_n=0 for 2 cycles with dec_valid=1 -> dec_ready=0, exu_wait=1, wb_en=0; after release dec_ready=1, FIFO empty, no writeback.
2. Push ADD rd=x1 rs1=x0 imm=5, then ADD rd=x2 rs1=x1 imm=3 back-to-back -> second issue exu_in1=5 (forwarded); wb: x1=5 then x2=8 on consecutive cycles.
3. ADD rd=x0 imm=7, then rs1=x0 -> wb_en=0 for the first op; second op exu_in1=rf_rs1_data (0), no forward.
4. stall_in=1, push 5 ops -> 4 accepted, dec_ready=0 when count=4; release stall -> 4 issues on consecutive cycles, exu_wait=0, FIFO order preserved.
5. 3 ops queued, 1 in EX, pulse flush_flag -> wb_en=0 that cycle; next cycle count=0, ex_valid=0, dec_ready=1; no stale writeback.
6. ISSUE_BYPASS_EN, empty FIFO, push ADD imm=9 -> exu_wait=0 in the push cycle, wb x-reg=9 the next cycle; without the macro, wb arrives one cycle later.

Source files
------------

// File: rtl/cpu_exu_issue_if.sv
// Operand/handshake bundle between the issue front end and its decode, RF, EXU and
// writeback neighbours. The issue block takes the slave side.
interface cpu_exu_issue_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_alu_ctrl;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_rd_we;
  logic        dec_use_imm;
  logic [31:0] dec_imm;

  logic [4:0]  rf_rs1_addr;
  logic [31:0] rf_rs1_data;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs2_data;

  logic [4:0]  exu_alu_ctrl;
  logic [31:0] exu_in1;
  logic [31:0] exu_in2;
  logic        exu_wait;
  logic [31:0] exu_out;

  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport slave (
    input  dec_valid, dec_alu_ctrl, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_use_imm, dec_imm,
    output dec_ready,
    output rf_rs1_addr, rf_rs2_addr,
    input  rf_rs1_data, rf_rs2_data,
    output exu_alu_ctrl, exu_in1, exu_in2, exu_wait,
    input  exu_out,
    output wb_en, wb_rd, wb_data
  );

  modport master (
    output dec_valid, dec_alu_ctrl, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_use_imm, dec_imm,
    input  dec_ready,
    input  rf_rs1_addr, rf_rs2_addr,
    output rf_rs1_data, rf_rs2_data,
    input  exu_alu_ctrl, exu_in1, exu_in2, exu_wait,
    output exu_out,
    input  wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/cpu_exu_issue.sv
// EXU issue/writeback front end: op FIFO, RF read, EX->issue forwarding, tagged writeback.
// Optional ISSUE_BYPASS_EN lets a decode op issue straight from dec_* when the FIFO is empty.
module cpu_exu_issue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush_flag,
  input logic          stall_in,
  cpu_exu_issue_if.slave bus
);

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        use_imm;
    logic [31:0] imm;
  } op_t;

  localparam logic [PTR_W:0] CountFull = DEPTH[PTR_W:0];

  op_t              mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ex_valid_q, ex_valid_d;
  logic             ex_we_q, ex_we_d;
  logic [4:0]       ex_rd_q, ex_rd_d;

  op_t  dec_op, head;
  logic empty, full, push, pop, issue, wr_en;
  logic ex_fwd_ok, fwd1, fwd2;

  assign dec_op = '{ctrl:    bus.dec_alu_ctrl,
                    rs1:     bus.dec_rs1,
                    rs2:     bus.dec_rs2,
                    rd:      bus.dec_rd,
                    rd_we:   bus.dec_rd_we,
                    use_imm: bus.dec_use_imm,
                    imm:     bus.dec_imm};

  assign empty         = (count_q == '0);
  assign full          = (count_q == CountFull);
  // Ready deliberately ignores a same-cycle pop, so a full FIFO never accepts.
  assign bus.dec_ready = rst_n & ~flush_flag & ~full;
  assign push          = bus.dec_valid & bus.dec_ready;
  assign pop           = rst_n & ~empty & ~stall_in & ~flush_flag;

`ifdef ISSUE_BYPASS_EN
  logic bypass;
  assign bypass = empty & push & ~stall_in;
  assign head   = bypass ? dec_op : mem_q[rd_ptr_q];
  assign issue  = pop | bypass;
  assign wr_en  = push & ~bypass;
`else
  assign head   = mem_q[rd_ptr_q];
  assign issue  = pop;
  assign wr_en  = push;
`endif

  // Operand read and forwarding from the op currently in EX.
  assign bus.rf_rs1_addr  = head.rs1;
  assign bus.rf_rs2_addr  = head.rs2;
  assign bus.exu_alu_ctrl = head.ctrl;
  assign bus.exu_wait     = ~issue;

  assign ex_fwd_ok   = ex_valid_q & ex_we_q & (ex_rd_q != 5'd0);
  assign fwd1        = ex_fwd_ok & (ex_rd_q == head.rs1);
  assign fwd2        = ex_fwd_ok & (ex_rd_q == head.rs2);
  assign bus.exu_in1 = fwd1 ? bus.exu_out : bus.rf_rs1_data;
  assign bus.exu_in2 = head.use_imm ? head.imm : (fwd2 ? bus.exu_out : bus.rf_rs2_data);

  assign bus.wb_en   = rst_n & ex_fwd_ok & ~flush_flag;
  assign bus.wb_rd   = ex_rd_q;
  assign bus.wb_data = bus.exu_out;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ex_valid_d = issue;
    ex_rd_d    = head.rd;
    ex_we_d    = head.rd_we;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_flag) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_we_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
    end
  end

  // Storage needs no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dec_op;
  end

endmodule

// File: tb/tb_cpu_exu_issue.sv
// Bench for cpu_exu_issue: directed per-cycle vector table, bypass latency sequence, and a
// randomized run checked against an in-order architectural model of the register file.
module tb_cpu_exu_issue;

  localparam logic [4:0] AluAdd = 5'd0;
  localparam logic [4:0] AluSub = 5'd1;
  localparam logic [4:0] AluXor = 5'd2;
  localparam logic [4:0] AluAnd = 5'd3;
  localparam logic [4:0] AluOr  = 5'd4;
`ifdef ISSUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct {
    bit          v;
    logic [4:0]  c, rs1, rs2, rd;
    bit          we, ui;
    logic [31:0] imm;
  } top_t;

  typedef struct {
    bit          rst, fl, st;
    top_t        op;
    bit          e_ready, e_wait, e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bit          ck1;
    logic [31:0] e_in1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_flag = 1'b0;
  logic stall_in = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  cpu_exu_issue_if bus ();

  cpu_exu_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_flag (flush_flag),
    .stall_in   (stall_in),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [4:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    case (c)
      AluAdd:  return a + b;
      AluSub:  return a - b;
      AluXor:  return a ^ b;
      AluAnd:  return a & b;
      default: return a | b;
    endcase
  endfunction

  // Environment: register file and a registered EXU that outputs 0 while waiting.
  logic [31:0] rf [32];
  logic [31:0] exu_out_q = 32'd0;
  assign bus.rf_rs1_data = rf[bus.rf_rs1_addr];
  assign bus.rf_rs2_data = rf[bus.rf_rs2_addr];
  assign bus.exu_out     = exu_out_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'h100 + i;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  always @(posedge clk) begin
    exu_out_q <= bus.exu_wait ? 32'd0 : alu(bus.exu_alu_ctrl, bus.exu_in1, bus.exu_in2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input top_t o);
    bus.dec_valid    = o.v;
    bus.dec_alu_ctrl = o.c;
    bus.dec_rs1      = o.rs1;
    bus.dec_rs2      = o.rs2;
    bus.dec_rd       = o.rd;
    bus.dec_rd_we    = o.we;
    bus.dec_use_imm  = o.ui;
    bus.dec_imm      = o.imm;
  endtask

  function automatic top_t op(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] imm);
    top_t o;
    o = '{v: 1'b1, c: AluAdd, rs1: rs1, rs2: 5'd0, rd: rd, we: 1'b1, ui: 1'b1, imm: imm};
    return o;
  endfunction

  function automatic top_t nop();
    top_t o;
    o = '{v: 1'b0, c: 5'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, we: 1'b0, ui: 1'b0, imm: 32'd0};
    return o;
  endfunction

  function automatic vec_t vv(input bit rst, input bit fl, input bit st, input top_t o,
                              input bit er, input bit ew, input bit ewb, input logic [4:0] erd,
                              input logic [31:0] ed, input bit ck, input logic [31:0] ein);
    vec_t v;
    v = '{rst: rst, fl: fl, st: st, op: o, e_ready: er, e_wait: ew, e_wb: ewb, e_rd: erd,
          e_data: ed, ck1: ck, e_in1: ein};
    return v;
  endfunction

  vec_t        tbl[$];
  logic [31:0] mreg [32];
  logic [36:0] expq[$];

  initial begin
    apply(nop());
    // Reset held with a valid op presented.
    tbl.push_back(vv(0, 0, 0, op(1, 0, 5), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(0, 0, 0, op(1, 0, 5), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 1, 0, 0, 0, 0, 0));
    // Dependent pair: x1 = x0+5, x2 = x1+3 with x1 forwarded.
    tbl.push_back(vv(1, 0, 1, op(1, 0, 5), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 1, op(2, 1, 3), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 0, 1, 1, 5, 1, 5));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 1, 1, 2, 8, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 1, 0, 0, 0, 0, 0));
    // rd=x0 is never written nor forwarded.
    tbl.push_back(vv(1, 0, 1, op(0, 0, 7), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 1, op(3, 0, 1), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(vv(1, 0, 0, nop(),       1, 1, 1, 3, 1, 0, 0));
    // Fill under stall: 4 accepted, 5th refused; then drain as a forwarding chain.
    for (int k = 0; k < 4; k++)
      tbl.push_back(vv(1, 0, 1, op(5'(4 + k), (k == 0) ? 5'd0 : 5'(3 + k), 32'(10 + k)),
                       1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 1, op(8, 7, 14), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(), 0, 0, 0, 0, 0,  1, 0));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 0, 1, 4, 10, 1, 10));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 0, 1, 5, 21, 1, 21));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 0, 1, 6, 33, 1, 33));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 1, 1, 7, 46, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 1, 0, 0, 0,  0, 0));
    // Flush with 3 queued and 1 in EX.
    for (int k = 0; k < 4; k++)
      tbl.push_back(vv(1, 0, 1, op(5'(9 + k), 0, 32'(20 + k)), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(), 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(vv(1, 1, 0, nop(), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vv(1, 0, 0, nop(), 1, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n      = tbl[i].rst;
      flush_flag = tbl[i].fl;
      stall_in   = tbl[i].st;
      apply(tbl[i].op);
      #2;
      check($sformatf("v%0d dec_ready", i), {31'd0, bus.dec_ready}, {31'd0, tbl[i].e_ready});
      check($sformatf("v%0d exu_wait", i), {31'd0, bus.exu_wait}, {31'd0, tbl[i].e_wait});
      check($sformatf("v%0d wb_en", i), {31'd0, bus.wb_en}, {31'd0, tbl[i].e_wb});
      if (tbl[i].e_wb) begin
        check($sformatf("v%0d wb_rd", i), {27'd0, bus.wb_rd}, {27'd0, tbl[i].e_rd});
        check($sformatf("v%0d wb_data", i), bus.wb_data, tbl[i].e_data);
      end
      if (tbl[i].ck1) check($sformatf("v%0d exu_in1", i), bus.exu_in1, tbl[i].e_in1);
    end
    apply(nop());
    @(negedge clk);
    check("rf x1", rf[1], 32'd5);
    check("rf x2", rf[2], 32'd8);
    check("rf x3", rf[3], 32'd1);
    check("rf x7", rf[7], 32'd46);
    check("rf x8 refused op", rf[8], 32'h108);
    check("rf x9 flushed op", rf[9], 32'h109);

    // Push into an empty FIFO with no stall: bypass removes one cycle of latency.
    for (int c = 0; c < 3; c++) begin
      apply((c == 0) ? op(13, 0, 9) : nop());
      #2;
      check($sformatf("byp c%0d exu_wait", c), {31'd0, bus.exu_wait},
            {31'd0, !(Byp ? (c == 0) : (c == 1))});
      check($sformatf("byp c%0d wb_en", c), {31'd0, bus.wb_en},
            {31'd0, Byp ? (c == 1) : (c == 2)});
      if (bus.wb_en) check($sformatf("byp c%0d wb_data", c), bus.wb_data, 32'd9);
      @(negedge clk);
    end

    // Randomized traffic; the model executes accepted ops in order on its own registers.
    for (int i = 0; i < 32; i++) mreg[i] = rf[i];
    for (int cyc = 0; cyc < 700; cyc++) begin
      top_t o;
      bit   go;
      go       = (cyc < 680);
      stall_in = go && ($urandom_range(0, 3) == 0);
      o.v      = go && ($urandom_range(0, 9) < 7);
      o.c      = 5'($urandom_range(0, 4));
      o.rs1    = 5'($urandom_range(0, 7));
      o.rs2    = 5'($urandom_range(0, 7));
      o.rd     = 5'($urandom_range(0, 7));
      o.we     = ($urandom_range(0, 9) != 0);
      o.ui     = $urandom_range(0, 1) == 1;
      o.imm    = $urandom;
      apply(o);
      #2;
      if (bus.wb_en) begin
        if (expq.size() == 0) begin
          check("rnd unexpected wb_en", 32'd1, 32'd0);
        end else begin
          logic [36:0] e;
          e = expq.pop_front();
          check($sformatf("rnd c%0d wb_rd", cyc), {27'd0, bus.wb_rd}, {27'd0, e[36:32]});
          check($sformatf("rnd c%0d wb_data", cyc), bus.wb_data, e[31:0]);
        end
      end
      if (bus.dec_valid && bus.dec_ready) begin
        logic [31:0] a, b, r;
        a = mreg[o.rs1];
        b = o.ui ? o.imm : mreg[o.rs2];
        r = alu(o.c, a, b);
        if (o.we && o.rd != 5'd0) begin
          mreg[o.rd] = r;
          expq.push_back({o.rd, r});
        end
      end
      @(negedge clk);
    end
    check("rnd pending writebacks", expq.size(), 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("rnd rf x%0d", i), rf[i], mreg[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
